uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Byte-stream packet deframer sitting directly downstream of the UART receiver. It consumes single-cycle received-byte strobes, hunts for a sync byte, then parses length, payload and an optional checksum. Payload bytes are buffered in a FIFO and presented on a valid/ready stream with start-of-packet, end-of-packet and error markers. The FIFO absorbs downstream stalls, because the UART receiver has no backpressure.

## Interface
- `FIFO_DEPTH`, default 16: number of payload entries; must be a power of 2 and ≥ 2.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_LEN`, default 64: largest legal payload length, range 1..255.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `i_rx_data`, in, 8: received byte; sampled only when `i_rx_valid` = 1.
- `i_rx_valid`, in, 1: single-cycle strobe, one per received byte.
- `o_pkt_data`, out, 8: payload byte at the FIFO head.
- `o_pkt_valid`, out, 1: FIFO not empty.
- `i_pkt_ready`, in, 1: consumer accepts the head entry when `o_pkt_valid` & `i_pkt_ready`.
- `o_pkt_sop`, out, 1: head entry is the first payload byte of a packet.
- `o_pkt_eop`, out, 1: head entry is the last payload byte of a packet.
- `o_pkt_err`, out, 1: meaningful only with `o_pkt_eop`; the packet is bad (checksum mismatch or overflow).
- `o_len_err`, out, 1: one-cycle pulse when a LEN byte is 0 or greater than `MAX_LEN`.
- `o_overflow`, out, 1: sticky; set when a push is dropped because the FIFO is full; cleared only by `rst`.

## Operation
Frame format: SYNC, LEN, LEN payload bytes, then CSUM when the checksum feature is enabled. CSUM is the XOR of the LEN byte and all payload bytes.

The parser FSM advances only on cycles where `i_rx_valid` = 1:
- **HUNT:** a byte equal to `SYNC_BYTE` moves to LEN; any other byte is discarded and the FSM stays in HUNT.
- **LEN:**
  - If the byte is 0 or greater than `MAX_LEN`: pulse `o_len_err` and return to HUNT.
  - Otherwise: load the remaining-byte counter with LEN, seed the checksum accumulator with LEN, set the sop flag, and go to PAYLOAD.
  - A byte equal to `SYNC_BYTE` here is treated as a length, not as a resync.
- **PAYLOAD:**
  - Each byte is XORed into the accumulator and the counter is decremented.
  - Non-final bytes are pushed to the FIFO as {sop, eop=0, err=0, data}. sop is 1 only on the first byte pushed.
  - With the checksum feature enabled, the final byte is held in a one-entry hold register and the FSM goes to CSUM.
  - With the checksum feature disabled, the final byte is pushed with eop=1 and the FSM goes to HUNT.
- **CSUM:** push the held byte with eop=1 and err = (accumulator ≠ byte) | ovf_pkt, then go to HUNT.

FIFO entry is 11 bits: {sop, eop, err, data}. The FIFO is first-word-fall-through: the outputs always show the head entry and are don't-care when `o_pkt_valid` = 0.

Overflow handling:
- A push while full with no simultaneous pop is dropped, `o_overflow` is set, and the per-packet flag ovf_pkt is set.
- ovf_pkt forces err=1 on that packet's eop entry.
- If the eop entry itself is dropped, the consumer sees the next sop without a preceding eop and must treat this as an error.
- ovf_pkt clears on entry to HUNT.

Full/empty and counters:
- A push and a pop in the same cycle while full is accepted; occupancy is unchanged.
- A push and a pop in the same cycle while empty: the push is stored and `o_pkt_valid` rises the next cycle.
- Pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. Occupancy is log2(`FIFO_DEPTH`)+1 bits.
- The remaining-byte counter is 8 bits and is never decremented below 1 while in PAYLOAD.

## Timing
- Reset values:
  - Outputs: `o_pkt_valid`=0, `o_len_err`=0, `o_overflow`=0.
  - Internal state: FSM=HUNT, FIFO empty, accumulator=0, hold register=0, ovf_pkt=0.
- Reset mid-packet discards the partial frame and all FIFO contents.
- Latency for non-final payload bytes: `i_rx_valid` in cycle N → `o_pkt_valid`/data visible in cycle N+1 when the FIFO was empty.
- Latency for the final payload byte with the checksum feature enabled: visible the cycle after the CSUM byte strobe.
- `o_len_err` is asserted in the cycle after the offending strobe and lasts exactly one cycle.
- `o_overflow` rises in the cycle after the dropped push.
- Back-to-back `i_rx_valid` strobes on consecutive cycles must be handled, although the UART receiver never produces them.
- `o_pkt_*` must hold stable while `o_pkt_valid` & !`i_pkt_ready`.

## Configuration
- `UART_DEFRAMER_CSUM_EN` defined: the frame carries the CSUM byte; the CSUM state, hold register and accumulator are built; `o_pkt_err` reports checksum mismatch | overflow.
- `UART_DEFRAMER_CSUM_EN` undefined: no CSUM byte in the frame; the CSUM state, hold register and accumulator are not built; eop is pushed with the last payload byte; `o_pkt_err` = overflow only.

## Structure
- Package `uart_pkg`:
  - typedef `deframer_state_t` {HUNT, LEN, PAYLOAD, CSUM}
  - typedef packed struct `deframer_entry_t` {sop, eop, err, data[7:0]}
  - default constant `UART_SYNC_BYTE` = 8'hA5
- One sub-module, `sync_fifo`: parameterised WIDTH and DEPTH, first-word-fall-through, exporting full, empty and count. It is instantiated with WIDTH=11.

## Test plan
- Strobes A5 03 11 22 33 03 with `i_pkt_ready`=1 (checksum enabled) → three beats: 11 (sop), 22, 33 (eop, err=0).
- Same frame with CSUM=04 → 33 is emitted with eop=1, err=1; a following good frame is parsed correctly.
- Strobes FF 00 A5 00 → no push; one `o_len_err` pulse, after the final 00; FSM in HUNT.
- Strobes A5 41 → `o_len_err` pulse; a subsequent A5 01 7E 7F → one beat 7E with sop=1, eop=1, err=0.
- `i_pkt_ready`=0; A5 14 + 20 payload bytes with `FIFO_DEPTH`=16 → `o_overflow`=1 after the 17th push attempt. Then raise `i_pkt_ready` → 16 beats drain, and the first has sop=1.
- `rst` asserted mid-PAYLOAD with 5 entries in the FIFO → next cycle `o_pkt_valid`=0, FSM in HUNT; a new frame parses cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART packet deframer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } deframer_state_t;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       err;
        logic [7:0] data;
    } deframer_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with full/empty/count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so a push while full is accepted alongside it.
    assign w_rd = i_rd_en & ~o_empty;
    assign w_wr = i_wr_en & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_deframer.sv
// ============================================================================
// Module      : uart_rx_deframer
// Description : Sync/length/payload[/checksum] deframer feeding a FWFT stream FIFO.
//               Define UART_DEFRAMER_CSUM_EN to parse and check the trailing CSUM byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  SYNC_BYTE  = UART_SYNC_BYTE,
    parameter int unsigned MAX_LEN    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_pkt_data,
    output logic       o_pkt_valid,
    input  logic       i_pkt_ready,
    output logic       o_pkt_sop,
    output logic       o_pkt_eop,
    output logic       o_pkt_err,
    output logic       o_len_err,
    output logic       o_overflow
);

    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    deframer_state_t r_state;
    deframer_state_t w_state_next;
    deframer_entry_t w_push_entry;
    deframer_entry_t w_head;
    logic [7:0]      r_remaining;
    logic            r_sop;
    logic            r_ovf_pkt;
    logic            r_len_err;
    logic            r_overflow;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_len_bad;
    logic            w_len_err_next;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

`ifdef UART_DEFRAMER_CSUM_EN
    logic [7:0] r_acc;
    logic [7:0] r_hold;
`endif

    assign w_len_bad = (i_rx_data == 8'd0) || (i_rx_data > c_max_len);

    always_comb begin
        w_state_next      = r_state;
        w_push            = 1'b0;
        w_len_err_next    = 1'b0;
        w_push_entry.sop  = r_sop;
        w_push_entry.eop  = 1'b0;
        w_push_entry.err  = 1'b0;
        w_push_entry.data = i_rx_data;
        if (i_rx_valid) begin
            case (r_state)
                HUNT: begin
                    if (i_rx_data == SYNC_BYTE) w_state_next = LEN;
                end
                LEN: begin
                    if (w_len_bad) begin
                        w_len_err_next = 1'b1;
                        w_state_next   = HUNT;
                    end else begin
                        w_state_next   = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (r_remaining == 8'd1) begin
`ifdef UART_DEFRAMER_CSUM_EN
                        w_state_next = CSUM;
`else
                        w_push           = 1'b1;
                        w_push_entry.eop = 1'b1;
                        w_push_entry.err = r_ovf_pkt;
                        w_state_next     = HUNT;
`endif
                    end else begin
                        w_push = 1'b1;
                    end
                end
                CSUM: begin
`ifdef UART_DEFRAMER_CSUM_EN
                    w_push            = 1'b1;
                    w_push_entry.data = r_hold;
                    w_push_entry.eop  = 1'b1;
                    w_push_entry.err  = (r_acc != i_rx_data) | r_ovf_pkt;
`endif
                    w_state_next = HUNT;
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= HUNT;
        else     r_state <= w_state_next;
    end

    assign w_pop  = o_pkt_valid & i_pkt_ready;
    assign w_drop = w_push & w_fifo_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= 8'd0;
            r_sop       <= 1'b0;
            r_ovf_pkt   <= 1'b0;
            r_len_err   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_len_err <= w_len_err_next;
            if (w_drop) r_overflow <= 1'b1;
            if (w_state_next == HUNT) r_ovf_pkt <= 1'b0;
            else if (w_drop)          r_ovf_pkt <= 1'b1;
            // sop marks the first push attempt, even if that push is dropped.
            if (w_push) r_sop <= 1'b0;
            if (i_rx_valid && r_state == LEN && !w_len_bad) begin
                r_remaining <= i_rx_data;
                r_sop       <= 1'b1;
            end
            if (i_rx_valid && r_state == PAYLOAD && r_remaining != 8'd1)
                r_remaining <= r_remaining - 8'd1;
        end
    end

`ifdef UART_DEFRAMER_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= 8'd0;
            r_hold <= 8'd0;
        end else if (i_rx_valid) begin
            if (r_state == LEN) r_acc <= i_rx_data;
            if (r_state == PAYLOAD) begin
                r_acc <= r_acc ^ i_rx_data;
                if (r_remaining == 8'd1) r_hold <= i_rx_data;
            end
        end
    end
`endif

    sync_fifo #(
        .WIDTH (11),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_entry),
        .i_rd_en   (i_pkt_ready),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign o_pkt_valid = ~w_fifo_empty;
    assign o_pkt_sop   = w_head.sop;
    assign o_pkt_eop   = w_head.eop;
    assign o_pkt_err   = w_head.err;
    assign o_pkt_data  = w_head.data;
    assign o_len_err   = r_len_err;
    assign o_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
// ============================================================================
// Module      : tb_uart_rx_deframer
// Description : Randomised frame-level scoreboard bench for uart_rx_deframer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_deframer;
    import uart_pkg::*;

`ifdef UART_DEFRAMER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_rx_data = 8'd0;
    logic       i_rx_valid = 1'b0;
    logic       i_pkt_ready = 1'b1;
    logic [7:0] o_pkt_data;
    logic       o_pkt_valid;
    logic       o_pkt_sop;
    logic       o_pkt_eop;
    logic       o_pkt_err;
    logic       o_len_err;
    logic       o_overflow;

    int              checks = 0;
    int              failures = 0;
    int              ready_mode = 1;
    deframer_entry_t sb[$];
    logic [7:0]      pl[$];
    deframer_entry_t mon_exp;
    deframer_entry_t mon_act;
    deframer_entry_t stall_ent;
    bit              stall_prev = 1'b0;

    uart_rx_deframer #(
        .FIFO_DEPTH (16),
        .SYNC_BYTE  (SYNC),
        .MAX_LEN    (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_pkt_data  (o_pkt_data),
        .o_pkt_valid (o_pkt_valid),
        .i_pkt_ready (i_pkt_ready),
        .o_pkt_sop   (o_pkt_sop),
        .o_pkt_eop   (o_pkt_eop),
        .o_pkt_err   (o_pkt_err),
        .o_len_err   (o_len_err),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer readiness: 0 = stalled, 1 = always ready, 2 = ready 3 cycles out of 4.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       i_pkt_ready = 1'b0;
            1:       i_pkt_ready = 1'b1;
            default: i_pkt_ready = ($urandom % 4) != 0;
        endcase
    end

    // Monitor: inputs settle by the falling edge, so what is seen here is what the next rising edge takes.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            mon_act = {o_pkt_sop, o_pkt_eop, o_pkt_err, o_pkt_data};
            if (stall_prev)
                chk("stall_hold", {o_pkt_valid, mon_act}, {1'b1, stall_ent});
            if (o_pkt_valid && i_pkt_ready) begin
                chk("beat_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_exp = sb.pop_front();
                    if (!mon_exp.eop) begin
                        mon_exp.err = 1'b0;
                        mon_act.err = 1'b0;
                    end
                    chk("beat", mon_act, mon_exp);
                end
            end
            stall_prev = o_pkt_valid && !i_pkt_ready;
            stall_ent  = mon_act;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit exp_le, input int gap);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
        chk("len_err_pulse", o_len_err, exp_le);
        if (exp_le) begin
            @(posedge clk);
            #1;
            chk("len_err_one_cycle", o_len_err, 0);
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit bad_csum, input int glo, input int ghi);
        deframer_entry_t e;
        logic [7:0]      len;
        logic [7:0]      csum;
        len  = 8'(pl.size());
        csum = len;
        foreach (pl[i]) begin
            e.sop  = (i == 0);
            e.eop  = (i == pl.size() - 1);
            e.err  = bad_csum && CSUM_EN;
            e.data = pl[i];
            sb.push_back(e);
            csum ^= pl[i];
        end
        if (bad_csum) csum ^= 8'(1 + $urandom % 255);
        send_byte(SYNC, 1'b0, $urandom_range(ghi, glo));
        send_byte(len, 1'b0, $urandom_range(ghi, glo));
        foreach (pl[i]) send_byte(pl[i], 1'b0, $urandom_range(ghi, glo));
        if (CSUM_EN) send_byte(csum, 1'b0, $urandom_range(ghi, glo));
    endtask

    task automatic rand_payload(input int len);
        pl.delete();
        repeat (len) pl.push_back(8'($urandom));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || o_pkt_valid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, {sb.size() == 0, !o_pkt_valid}, 2'b11);
    endtask

    task automatic random_phase(input int iters, input int glo, input int ghi);
        logic [7:0] b;
        for (int k = 0; k < iters; k++) begin
            case ($urandom % 8)
                0: begin
                    b = 8'($urandom);
                    if (b == SYNC) b = 8'h5A;
                    send_byte(b, 1'b0, $urandom_range(ghi, glo));
                end
                1: begin
                    send_byte(SYNC, 1'b0, $urandom_range(ghi, glo));
                    b = ($urandom % 2) ? 8'd0 : 8'($urandom_range(255, 65));
                    send_byte(b, 1'b1, $urandom_range(ghi, glo));
                end
                default: begin
                    rand_payload(($urandom % 10 == 0) ? 64 : $urandom_range(24, 1));
                    send_frame(($urandom % 4) == 0, glo, ghi);
                end
            endcase
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", o_pkt_valid, 0);
        chk("reset_len_err", o_len_err, 0);
        chk("reset_overflow", o_overflow, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid", o_pkt_valid, 0);

        // Directed frames from the basic scenarios.
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b0, 0, 0);
        drain("drain_good");
        send_frame(1'b1, 0, 1);
        pl = '{8'h44, 8'h55};
        send_frame(1'b0, 0, 1);
        drain("drain_badcsum");
        send_byte(8'hFF, 1'b0, 1);
        send_byte(8'h00, 1'b0, 1);
        send_byte(SYNC, 1'b0, 1);
        send_byte(8'h00, 1'b1, 1);
        chk("no_push_after_len0", {sb.size() == 0, o_pkt_valid}, 2'b10);
        send_byte(SYNC, 1'b0, 0);
        send_byte(8'h41, 1'b1, 0);
        pl = '{8'h7E};
        send_frame(1'b0, 0, 0);
        drain("drain_single");
        send_byte(SYNC, 1'b0, 0);
        send_byte(SYNC, 1'b1, 0);
        rand_payload(64);
        send_frame(1'b0, 0, 0);
        drain("drain_maxlen");

        random_phase(40, 0, 2);
        drain("drain_rand_fast");
        ready_mode = 2;
        random_phase(40, 2, 4);
        ready_mode = 1;
        drain("drain_rand_stall");
        chk("no_overflow_yet", o_overflow, 0);

        // Overflow: 20 payload bytes into a stalled 16-entry FIFO.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rand_payload(20);
        for (int i = 0; i < 16; i++) begin
            mon_exp.sop  = (i == 0);
            mon_exp.eop  = 1'b0;
            mon_exp.err  = 1'b0;
            mon_exp.data = pl[i];
            sb.push_back(mon_exp);
        end
        send_byte(SYNC, 1'b0, 0);
        send_byte(8'd20, 1'b0, 0);
        for (int k = 1; k <= 20; k++) begin
            send_byte(pl[k-1], 1'b0, 0);
            chk("overflow_flag", o_overflow, (k >= 17) ? 1 : 0);
        end
        if (CSUM_EN) send_byte(8'h00, 1'b0, 0);
        ready_mode = 1;
        drain("drain_overflow");
        chk("overflow_sticky", o_overflow, 1);
        rand_payload(5);
        send_frame(1'b0, 0, 1);
        drain("drain_after_overflow");

        // Reset in the middle of a payload with five entries buffered.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_byte(SYNC, 1'b0, 0);
        send_byte(8'd10, 1'b0, 0);
        for (int k = 0; k < 5; k++) send_byte(8'(k + 1), 1'b0, 0);
        chk("prereset_valid", o_pkt_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_valid", o_pkt_valid, 0);
        chk("midreset_overflow", o_overflow, 0);
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        pl = '{8'hA5, 8'h01, 8'hC3};
        send_frame(1'b0, 0, 1);
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
